// File: rtl/morse_key_capture_pkg.sv
// Shared types and constants for the Morse key capture front end.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        GAP     = 3'd2,
        HOLD    = 3'd3,
        WAIT_UP = 3'd4
    } state_t;

    localparam logic MORSE_DOT     = 1'b0;
    localparam logic MORSE_DASH    = 1'b1;
    localparam int   MORSE_MAX_SYM = 5;

    // Defaults assume a 100 MHz clock.
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_DASH_CYC     = 20_000_000;
    localparam int DEF_GAP_CYC      = 60_000_000;
    localparam int DEF_HOLD_CYC     = 1_000_100;
    localparam int DEF_CNT_W        = 26;

endpackage

// File: rtl/morse_key_capture_if.sv
// Key input, abort pulse and symbol-buffer outputs of the capture stage.
interface morse_key_capture_if;
    import morse_pkg::*;

    logic                     key;
    logic                     clr;
    logic [MORSE_MAX_SYM-1:0] led_morse;
    logic [2:0]               led_cnt;
    logic                     trans;
    logic                     err;
    logic                     busy;

    modport master (
        output key, clr,
        input  led_morse, led_cnt, trans, err, busy
    );

    modport slave (
        input  key, clr,
        output led_morse, led_cnt, trans, err, busy
    );
endinterface

// File: rtl/morse_key_capture_key_debouncer.sv
// Two-flop synchroniser followed by a stable-level debounce filter.
module key_debouncer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_db
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             key_meta;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            key_db <= 1'b0;
        end else if (key_sync == key_db) begin
            cnt <= '0;
        end else if (cnt == DB_LAST) begin
            cnt    <= '0;
            key_db <= key_sync;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end
endmodule

// File: rtl/morse_key_capture.sv
// Morse key front end: classifies presses as dot/dash, buffers up to five
// symbols and strobes trans once an inter-letter gap has elapsed.
//
// state   | meaning
// IDLE    | buffer empty, waiting for a press
// PRESS   | key down, dur measuring the press
// GAP     | key up, gap measuring the silence after the last symbol
// HOLD    | letter committed, buffer frozen for the downstream stage
// WAIT_UP | key ignored until it is released
module morse_key_capture
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int DASH_CYC     = DEF_DASH_CYC,
    parameter int GAP_CYC      = DEF_GAP_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input logic          clk,
    input logic          rst,
    morse_key_capture_if.slave bus
);
    localparam logic [CNT_W-1:0] DASH_MIN  = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       SYM_FULL  = 3'(MORSE_MAX_SYM);

    state_t                   state;
    logic [CNT_W-1:0]         dur;
    logic [CNT_W-1:0]         gap;
    logic [CNT_W-1:0]         hold;
    logic [MORSE_MAX_SYM-1:0] led_morse;
    logic [2:0]               led_cnt;
    logic                     trans;
    logic                     err;
    logic                     busy;
    logic                     key_db;

    key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_db (
        .clk    (clk),
        .rst    (rst),
        .key    (bus.key),
        .key_db (key_db)
    );

    // Capture FSM with its counters, symbol buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dur       <= '0;
            gap       <= '0;
            hold      <= '0;
            led_morse <= '0;
            led_cnt   <= '0;
            trans     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            trans <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_db) begin
                        dur   <= '0;
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    if (bus.clr) begin
                        led_morse <= '0;
                        led_cnt   <= '0;
                        err       <= 1'b0;
                        state     <= key_db ? WAIT_UP : IDLE;
                    end else if (!key_db) begin
                        if (led_cnt < SYM_FULL) begin
                            led_morse <= {led_morse[MORSE_MAX_SYM-2:0],
                                          (dur >= DASH_MIN) ? MORSE_DASH : MORSE_DOT};
                            led_cnt   <= led_cnt + 3'd1;
                        end else begin
                            err <= 1'b1;
                        end
                        gap   <= '0;
                        state <= GAP;
                    end else if (dur != '1) begin
                        dur <= dur + CNT_ONE;
                    end
                end
                GAP: begin
                    if (bus.clr) begin
                        led_morse <= '0;
                        led_cnt   <= '0;
                        err       <= 1'b0;
                        state     <= key_db ? WAIT_UP : IDLE;
                    end else if (key_db) begin
                        dur   <= '0;
                        state <= PRESS;
                    end else if (gap == GAP_LAST) begin
                        trans <= 1'b1;
                        hold  <= '0;
                        state <= HOLD;
                    end else begin
                        gap <= gap + CNT_ONE;
                    end
                end
                HOLD: begin
                    // The trans cycle itself does not count toward the hold time.
                    if (trans) begin
                        busy <= 1'b1;
                    end else if (hold == HOLD_LAST) begin
                        led_morse <= '0;
                        led_cnt   <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        state     <= key_db ? WAIT_UP : IDLE;
                    end else begin
                        hold <= hold + CNT_ONE;
                    end
                end
                WAIT_UP: begin
                    if (bus.clr) begin
                        led_morse <= '0;
                        led_cnt   <= '0;
                        err       <= 1'b0;
                        state     <= key_db ? WAIT_UP : IDLE;
                    end else if (!key_db) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led_morse = led_morse;
    assign bus.led_cnt   = led_cnt;
    assign bus.trans     = trans;
    assign bus.err       = err;
    assign bus.busy      = busy;
endmodule

// File: doc/morse_key_capture.md
# morse_key_capture

Front-end stage of the Morse decoder: it turns the raw Morse key into a symbol buffer and a commit strobe. It synchronises and debounces the key and classifies each press as dot or dash by duration. It accumulates up to five symbols, then issues a one-cycle `trans` when an inter-letter gap elapses. The buffer is held stable long enough for the downstream translation stage to capture it.

## Interface
- `DEBOUNCE_CYC`, 1_000_000: number of consecutive stable cycles required to accept a key level change (10 ms at 100 MHz).
- `DASH_CYC`, 20_000_000: a press of at least this many cycles is a dash; a shorter press is a dot.
- `GAP_CYC`, 60_000_000: key-up cycles after the last symbol that trigger a commit.
- `HOLD_CYC`, 1_000_100: cycles the buffer is held after `trans`. Must exceed the downstream capture delay of 1_000_001 cycles.
- `CNT_W`, 26: width of the timing counters. Must hold the largest timing parameter.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key` in 1: raw Morse key, active-high, asynchronous to `clk`.
- `clr` in 1: synchronous one-cycle pulse that aborts the current letter.
- `led_morse` out 5: symbol bits. Each new symbol shifts in at bit 0; dash=1, dot=0. The first symbol ends up in the highest used bit.
- `led_cnt` out 3: number of valid symbols, 0..5.
- `trans` out 1: one-cycle commit strobe.
- `err` out 1: overflow flag. Set when a 6th symbol is attempted; cleared at buffer clear.
- `busy` out 1: high in HOLD state.

## Operation
- Key path: 2-FF synchroniser → `key_sync`. `key_db` follows `key_sync` only after `key_sync` ≠ `key_db` for `DEBOUNCE_CYC` consecutive cycles. Any mismatch break restarts the count.
- FSM states:
  - IDLE: buffer empty. `key_db` rise → PRESS.
  - PRESS: `dur` increments each cycle and saturates at all-ones.
    - On `key_db` fall, compute symbol = (`dur` ≥ `DASH_CYC`).
    - If `led_cnt` < 5: `led_morse` ← {`led_morse[3:0]`, symbol} and `led_cnt`++.
    - Else: buffer unchanged and `err` ← 1.
    - Either way → GAP with `gap` = 0.
  - GAP: `gap` increments each cycle.
    - `key_db` rise → PRESS with `dur` = 0.
    - `gap` == `GAP_CYC`-1 → `trans` = 1 for one cycle → HOLD with `hold` = 0.
  - HOLD: `led_morse`, `led_cnt` and `err` are frozen. `key_db` edges are ignored.
    - When `hold` == `HOLD_CYC`-1, clear the buffer and `err`.
    - If `key_db` is high at that moment → WAIT_UP, otherwise → IDLE.
  - WAIT_UP: ignore the key until `key_db` falls, then → IDLE. A press held through HOLD is not a symbol.
- `clr` in PRESS, GAP or WAIT_UP: clear the buffer and `err`, then go to WAIT_UP if `key_db` is high, else IDLE. No `trans` is issued.
- `clr` in HOLD is ignored, so a commit already issued completes.
- `rst` at any time: all state returns to reset values immediately, including mid-PRESS and mid-HOLD. No `trans` is issued.
- Reset values: `led_morse`=0, `led_cnt`=0, `trans`=0, `err`=0, `busy`=0, FSM=IDLE, `key_db`=0, synchroniser=0, all counters=0.

## Timing
- `key` edge → `key_db` edge: 2 + `DEBOUNCE_CYC` cycles.
- Buffer update: on the clock edge following the cycle in which `key_db` is first seen low.
- `trans` is high exactly `GAP_CYC` cycles after the buffer-update edge, provided no press occurs.
- While `trans` is high, the buffer already holds the final letter.
- The buffer stays constant for `HOLD_CYC` cycles after the `trans` cycle. It reads zero on the following edge.
- `busy` is high from the cycle after `trans` until the clear edge, inclusive.
- Dash decision at `dur` == `DASH_CYC` exactly → dash.

## Structure
- Package `morse_pkg`:
  - FSM state enum: IDLE, PRESS, GAP, HOLD, WAIT_UP.
  - Constants: `MORSE_DOT`=0, `MORSE_DASH`=1, `MORSE_MAX_SYM`=5.
  - Default timing constants.
- Sub-module `key_debouncer`: contains the synchroniser and debounce counter, parameterised by `DEBOUNCE_CYC` and `CNT_W`. Output is `key_db`.
- Top level contains the FSM, the `dur`/`gap`/`hold` counters and the symbol buffer.

## Test plan
Use parameters `DEBOUNCE_CYC`=4, `DASH_CYC`=20, `GAP_CYC`=50, `HOLD_CYC`=30.
- Letter A: `key` high 10 cycles, low 10 cycles, high 30 cycles, then low. Required response:
  - `led_morse`=00001 and `led_cnt`=2.
  - `trans` pulses once, 50 cycles after the second update.
  - Buffer stays stable for 30 cycles, then reads 0/0.
- Digit 0: five presses of 30 cycles each, with 10-cycle gaps → `led_morse`=11111, `led_cnt`=5, `err`=0, single `trans`.
- Glitch rejection: `key` pulses of 3 cycles, repeated → `key_db` stays 0 and no buffer change.
- Overflow: six dot presses → after the 6th, `led_morse`=00000, `led_cnt`=5, `err`=1. `err` clears with the buffer after HOLD.
- Press during HOLD: key pressed 5 cycles after `trans` and held 40 cycles. Required response:
  - Buffer is unchanged during HOLD and cleared on schedule.
  - FSM passes through WAIT_UP, and no symbol is recorded for that press.
- Reset/abort:
  - `rst` asserted mid-PRESS with `led_cnt`=3 → all outputs 0; the next E press gives 00000/1.
  - `clr` in GAP → buffer zero and no `trans` pulse.
